apb_req_arbiter: RTL and testbench

//  Shares the single APB_Master internal port (transfer/ready/addr/wdata/rdata/write)

---
 rtl/apb_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester front end for the single APB_Master port: latches one-cycle
// request pulses, arbitrates (round-robin or fixed priority), issues one
// transfer at a time and routes the completion back to the granted requester.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_transfer,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_busy,
  input  logic              req1_transfer,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_busy,
  output logic              m_transfer,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic              pend0, pend1;
  logic              last_grant;
  logic              p0_write, p1_write;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;

  logic busy0, busy1;
  logic cap0, cap1;
  logic grant_go;
  logic win;

  // Busy/capture qualification, winner selection and completion routing.
  always_comb begin
    busy0    = pend0 | ((state != IDLE) & ~grant_id);
    busy1    = pend1 | ((state != IDLE) & grant_id);
    cap0     = req0_transfer & ~busy0;
    cap1     = req1_transfer & ~busy1;
    grant_go = (state == IDLE) & (pend0 | pend1);
    win      = 1'b0;
    if (pend0 && pend1) begin
      win = ROUND_ROBIN ? ~last_grant : 1'b0;
    end else begin
      win = pend1;
    end
    req0_ready = (state == WAIT) & m_ready & ~grant_id;
    req1_ready = (state == WAIT) & m_ready & grant_id;
    req0_rdata = req0_ready ? m_rdata : '0;
    req1_rdata = req1_ready ? m_rdata : '0;
  end

  assign req0_busy = busy0;
  assign req1_busy = busy1;

  // Requester 0 pending flag and latched transfer fields.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pend0    <= 1'b0;
      p0_write <= 1'b0;
      p0_addr  <= '0;
      p0_wdata <= '0;
    end else if (cap0) begin
      pend0    <= 1'b1;
      p0_write <= req0_write;
      p0_addr  <= req0_addr;
      p0_wdata <= req0_wdata;
    end else if (grant_go && !win) begin
      pend0    <= 1'b0;
    end
  end

  // Requester 1 pending flag and latched transfer fields.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pend1    <= 1'b0;
      p1_write <= 1'b0;
      p1_addr  <= '0;
      p1_wdata <= '0;
    end else if (cap1) begin
      pend1    <= 1'b1;
      p1_write <= req1_write;
      p1_addr  <= req1_addr;
      p1_wdata <= req1_wdata;
    end else if (grant_go && win) begin
      pend1    <= 1'b0;
    end
  end

  // Transfer sequencer: grant in IDLE, pulse m_transfer in ISSUE, hold in WAIT.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      m_transfer <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_go) begin
            grant_id   <= win;
            last_grant <= win;
            m_write    <= win ? p1_write : p0_write;
            m_addr     <= win ? p1_addr  : p0_addr;
            m_wdata    <= win ? p1_wdata : p0_wdata;
            m_transfer <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          m_transfer <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (m_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          m_transfer <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus; expected transfers are queued when
// requests are driven and compared when the master port issues/completes.
module tb_apb_req_arbiter;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0_transfer, req0_write, req1_transfer, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  logic        req0_ready, req0_busy, req1_ready, req1_busy;
  logic [31:0] req0_rdata, req1_rdata;
  logic        m_transfer, m_write, grant_id;
  logic [31:0] m_addr, m_wdata;

  logic        fp_req0_ready, fp_req0_busy, fp_req1_ready, fp_req1_busy;
  logic [31:0] fp_req0_rdata, fp_req1_rdata;
  logic        fp_m_transfer, fp_m_write, fp_grant_id;
  logic [31:0] fp_m_addr, fp_m_wdata;

  int    checks = 0;
  int    errors = 0;
  xfer_t rr_q[$];
  xfer_t fp_q[$];
  logic  rr_last;
  logic  cur_id, fp_cur;

  initial forever #5 PCLK = ~PCLK;

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b1)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_transfer(req0_transfer), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_busy(req0_busy),
    .req1_transfer(req1_transfer), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_busy(req1_busy),
    .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .grant_id(grant_id)
  );

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b0)) dut_fp (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_transfer(req0_transfer), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(fp_req0_ready), .req0_rdata(fp_req0_rdata), .req0_busy(fp_req0_busy),
    .req1_transfer(req1_transfer), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(fp_req1_ready), .req1_rdata(fp_req1_rdata), .req1_busy(fp_req1_busy),
    .m_transfer(fp_m_transfer), .m_write(fp_m_write), .m_addr(fp_m_addr), .m_wdata(fp_m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .grant_id(fp_grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_m_transfer", 32'(m_transfer), 0);
    chk("rst_m_write", 32'(m_write), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
    chk("rst_rdata0", req0_rdata, 0);
    chk("rst_rdata1", req1_rdata, 0);
    chk("rst_busy", 32'({req0_busy, req1_busy}), 0);
    chk("rst_fp_outs", 32'({fp_m_transfer, fp_m_write, fp_grant_id, fp_req0_busy, fp_req1_busy}), 0);
    chk("rst_fp_addr", fp_m_addr, 0);
  endtask

  task automatic do_reset();
    PRESET = 1'b0;
    #2;
    check_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET  = 1'b1;
    rr_last = 1'b1;
    @(posedge PCLK);
    #1;
  endtask

  // Drives a one-cycle request pulse; called just after a rising edge.
  task automatic pulse(input logic id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (!id) begin
      req0_transfer = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_transfer = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
    @(posedge PCLK);
    #1;
    req0_transfer = 1'b0;
    req1_transfer = 1'b0;
  endtask

  task automatic single(input logic id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    rr_q.push_back('{id, wr, a, d});
    fp_q.push_back('{id, wr, a, d});
    rr_last = id;
    pulse(id, wr, a, d);
  endtask

  // Simultaneous reads from both requesters.
  task automatic pair(input logic [31:0] a0, input logic [31:0] a1);
    logic w;
    w = ~rr_last;
    rr_q.push_back('{w, 1'b0, w ? a1 : a0, 32'h0});
    rr_q.push_back('{~w, 1'b0, w ? a0 : a1, 32'h0});
    fp_q.push_back('{1'b0, 1'b0, a0, 32'h0});
    fp_q.push_back('{1'b1, 1'b0, a1, 32'h0});
    rr_last = ~w;
    req0_transfer = 1'b1; req0_write = 1'b0; req0_addr = a0; req0_wdata = 32'h0;
    req1_transfer = 1'b1; req1_write = 1'b0; req1_addr = a1; req1_wdata = 32'h0;
    @(posedge PCLK);
    #1;
    req0_transfer = 1'b0;
    req1_transfer = 1'b0;
  endtask

  // Waits (bounded) for m_transfer and compares the issued transfer with the scoreboard.
  task automatic expect_issue(output int n);
    xfer_t e, f;
    logic  found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge PCLK);
      n++;
      if (m_transfer === 1'b1) found = 1'b1;
    end
    chk("issue_seen", 32'(found), 1);
    if (found) begin
      chk("sb_has_entry", 32'(rr_q.size() > 0 && fp_q.size() > 0), 1);
      if (rr_q.size() > 0 && fp_q.size() > 0) begin
        e = rr_q.pop_front();
        f = fp_q.pop_front();
        cur_id = e.id;
        fp_cur = f.id;
        chk("issue_grant", 32'(grant_id), 32'(e.id));
        chk("issue_write", 32'(m_write), 32'(e.wr));
        chk("issue_addr", m_addr, e.addr);
        chk("issue_wdata", m_wdata, e.wdata);
        chk("fp_issue_xfer", 32'(fp_m_transfer), 1);
        chk("fp_issue_grant", 32'(fp_grant_id), 32'(f.id));
        chk("fp_issue_addr", fp_m_addr, f.addr);
        chk("issue_no_ready", 32'({req0_ready, req1_ready, fp_req0_ready, fp_req1_ready}), 0);
        chk("issue_rdata_gated", req0_rdata | req1_rdata, 0);
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  // Holds WAIT for idle cycles, then returns m_ready with rd and checks routing.
  task automatic complete(input logic [31:0] rd, input int idle, input bit repulse);
    for (int i = 0; i < idle; i++) begin
      @(negedge PCLK);
      chk("wait_no_xfer", 32'(m_transfer), 0);
      chk("wait_no_ready", 32'({req0_ready, req1_ready}), 0);
      @(posedge PCLK);
      #1;
    end
    m_ready = 1'b1;
    m_rdata = rd;
    if (repulse) begin
      if (!cur_id) begin
        req0_transfer = 1'b1; req0_write = 1'b1; req0_addr = 32'h4; req0_wdata = 32'h99;
      end else begin
        req1_transfer = 1'b1; req1_write = 1'b1; req1_addr = 32'h4; req1_wdata = 32'h99;
      end
    end
    @(negedge PCLK);
    chk("done_ready", 32'(cur_id ? req1_ready : req0_ready), 1);
    chk("done_rdata", cur_id ? req1_rdata : req0_rdata, rd);
    chk("other_ready", 32'(cur_id ? req0_ready : req1_ready), 0);
    chk("other_rdata", cur_id ? req0_rdata : req1_rdata, 0);
    chk("done_busy", 32'(cur_id ? req1_busy : req0_busy), 1);
    chk("fp_done_ready", 32'(fp_cur ? fp_req1_ready : fp_req0_ready), 1);
    chk("fp_done_rdata", fp_cur ? fp_req1_rdata : fp_req0_rdata, rd);
    chk("fp_other_ready", 32'(fp_cur ? fp_req0_ready : fp_req1_ready), 0);
    @(posedge PCLK);
    #1;
    m_ready       = 1'b0;
    m_rdata       = JUNK;
    req0_transfer = 1'b0;
    req1_transfer = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    req0_transfer = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_transfer = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    m_ready = 1'b0;
    m_rdata = JUNK;
    rr_last = 1'b1;
    cur_id  = 1'b0;
    fp_cur  = 1'b0;

    do_reset();

    // Lone write from req0: two-cycle issue latency, completion to req0 only.
    single(1'b0, 1'b1, 32'h1000_2000, 32'h0000_00A5);
    expect_issue(n);
    chk("latency", 32'(n), 2);
    complete(32'h0, 2, 1'b0);

    // Simultaneous reads after reset, then alternation once req0 was last.
    do_reset();
    pair(32'h100, 32'h200);
    expect_issue(n);
    complete(32'h11, 0, 1'b0);
    expect_issue(n);
    chk("b2b_bubble", 32'(n), 2);
    complete(32'h22, 1, 1'b0);
    single(1'b0, 1'b0, 32'h104, 32'h0);
    expect_issue(n);
    complete(32'h33, 0, 1'b0);
    pair(32'h108, 32'h208);
    expect_issue(n);
    complete(32'h44, 0, 1'b0);
    expect_issue(n);
    complete(32'h55, 0, 1'b0);

    // Another tie: fixed-priority instance still serves req0 first.
    pair(32'h10C, 32'h20C);
    expect_issue(n);
    complete(32'h66, 1, 1'b0);
    expect_issue(n);
    complete(32'h67, 0, 1'b0);

    // Read data routed to req1 only.
    single(1'b1, 1'b0, 32'h1000_3000, 32'h0);
    expect_issue(n);
    complete(32'h0000_005A, 0, 1'b0);

    // Pulses while busy (pending, and on its own ready cycle) are dropped.
    single(1'b0, 1'b1, 32'h10, 32'h55);
    pulse(1'b0, 1'b1, 32'h4, 32'h99);
    expect_issue(n);
    complete(32'h0, 1, 1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("stray_ready_ignored", 32'({m_transfer, req0_ready, req1_ready, req0_busy}), 0);
      chk("fp_stray_ready", 32'({fp_m_transfer, fp_req0_ready, fp_req0_busy}), 0);
    end
    @(posedge PCLK);
    #1;
    m_ready = 1'b0;

    // req1 captured during req0's WAIT, then reset hits during req1's WAIT with req0 pending.
    single(1'b0, 1'b1, 32'h1000_2004, 32'h66);
    expect_issue(n);
    single(1'b1, 1'b0, 32'h1000_3008, 32'h0);
    chk("req1_pend_in_wait", 32'(req1_busy), 1);
    complete(32'h77, 0, 1'b0);
    expect_issue(n);
    pulse(1'b0, 1'b1, 32'h1000_2008, 32'h88);
    chk("req0_pend_before_rst", 32'(req0_busy), 1);
    PRESET = 1'b0;
    #2;
    check_reset();
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      chk("post_rst_quiet", 32'({m_transfer, req0_busy, req1_busy, fp_m_transfer}), 0);
    end
    chk("sb_empty", 32'(rr_q.size() + fp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
